regfile_debug_port: RTL and testbench

Debug initiator for the 8×8-bit register file. It accepts dump or load commands, then sweeps a contiguous, wrapping range of register addresses. Dump reads registers out as a valid/ready byte stream; load writes registers from an incoming valid/ready byte stream. It sits beside the core datapath; an external mux grants it the register-file ports while `busy` is high.

---
 rtl/regfile_debug_port.sv | 185 ++++++++++++++++++
 tb/tb_regfile_debug_port.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_port.sv
// ---------------------------------------------------------------------------
// regfile_debug_port
//
// Debug initiator for a small register file. A command selects dump or load
// and a contiguous, wrapping range of register addresses. Dump streams the
// registers out on a valid/ready byte interface; load writes registers from
// an incoming valid/ready byte stream. While busy is high an external mux
// hands this block the register-file ports.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_op                       0 = dump, 1 = load
//   cmd_start                    first register address
//   cmd_count                    register count; 0 or > NUM_REGS means all
//   rf_read_addr/rf_read_data    register-file read port (combinational data)
//   rf_write_en/addr/data        registered register-file write port
//   dout_valid/dout_data/ready   dump byte stream
//   din_valid/din_data/ready     load byte stream
//   busy                         high whenever a command is in progress
//   done                         one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module regfile_debug_port #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_start,
  input  logic [ADDR_W:0]   cmd_count,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout_data,
  input  logic              dout_ready,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DUMP_RD   = 3'd1,
    S_DUMP_WAIT = 3'd2,
    S_LOAD      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   L_FULL    = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0]   L_REM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] L_PTR_ONE = ADDR_W'(1);

  // A zero or oversized count means "sweep the whole file once".
  function automatic logic [ADDR_W:0] norm_count(input logic [ADDR_W:0] c);
    logic [ADDR_W:0] res;
    if ((c == '0) || (c > L_FULL)) begin
      res = L_FULL;
    end else begin
      res = c;
    end
    return res;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [ADDR_W:0]     r_rem;
  logic [ADDR_W:0]     w_rem_nxt;
  logic                r_dout_valid;
  logic                w_dout_valid_nxt;
  logic [DATA_W-1:0]   r_dout_data;
  logic [DATA_W-1:0]   w_dout_data_nxt;
  logic                r_wr_en;
  logic                w_wr_en_nxt;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   r_wr_data;
  logic [DATA_W-1:0]   w_wr_data_nxt;

  // State and datapath registers; reset aborts any command in flight,
  // dropping a pending write strobe and any unacknowledged dump byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_rem        <= '0;
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_rem        <= w_rem_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_dout_data  <= w_dout_data_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
    end
  end

  // Next-state and next-datapath logic for the command sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_rem_nxt        = r_rem;
    w_dout_valid_nxt = r_dout_valid;
    w_dout_data_nxt  = r_dout_data;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_ptr_nxt   = cmd_start;
          w_rem_nxt   = norm_count(cmd_count);
          w_state_nxt = cmd_op ? S_LOAD : S_DUMP_RD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DUMP_RD: begin
        // Read data is combinational from rf_read_addr (= r_ptr).
        w_dout_data_nxt  = rf_read_data;
        w_dout_valid_nxt = 1'b1;
        w_state_nxt      = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (dout_ready) begin
          w_dout_valid_nxt = 1'b0;
          w_ptr_nxt        = r_ptr + L_PTR_ONE;
          w_rem_nxt        = r_rem - L_REM_ONE;
          w_state_nxt      = (r_rem == L_REM_ONE) ? S_DONE : S_DUMP_RD;
        end else begin
          w_state_nxt = S_DUMP_WAIT;
        end
      end
      S_LOAD: begin
        if (din_valid) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_ptr;
          w_wr_data_nxt = din_data;
          w_ptr_nxt     = r_ptr + L_PTR_ONE;
          w_rem_nxt     = r_rem - L_REM_ONE;
          w_state_nxt   = (r_rem == L_REM_ONE) ? S_DONE : S_LOAD;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_dout_valid_nxt = 1'b0;
      end
    endcase
  end

  // Status and handshake outputs are decoded straight from the state
  // register so that they fall together with reset.
  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign din_ready     = (r_state == S_LOAD);
  assign rf_read_addr  = r_ptr;
  assign dout_valid    = r_dout_valid;
  assign dout_data     = r_dout_data;
  assign rf_write_en   = r_wr_en;
  assign rf_write_addr = r_wr_addr;
  assign rf_write_data = r_wr_data;

endmodule

// File: tb/tb_regfile_debug_port.sv
// ---------------------------------------------------------------------------
// tb_regfile_debug_port
//
// Directed bench for regfile_debug_port. A small register-file model sits on
// the DUT's rf ports; exp_rf is the bench's own record of what every
// register should hold and is updated only from the bench's stimulus.
// ---------------------------------------------------------------------------
module tb_regfile_debug_port;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [2:0] cmd_start;
  logic [3:0] cmd_count;
  logic [2:0] rf_read_addr;
  logic [7:0] rf_read_data;
  logic       rf_write_en;
  logic [2:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic       dout_valid;
  logic [7:0] dout_data;
  logic       dout_ready;
  logic       din_valid;
  logic [7:0] din_data;
  logic       din_ready;
  logic       busy;
  logic       done;

  logic [7:0] rf [8];
  logic [7:0] exp_rf [8];
  logic [7:0] ld_bytes [8];
  logic       preload;
  int         cyc;
  int         checks;
  int         failures;

  regfile_debug_port #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_start     (cmd_start),
    .cmd_count     (cmd_count),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .dout_valid    (dout_valid),
    .dout_data     (dout_data),
    .dout_ready    (dout_ready),
    .din_valid     (din_valid),
    .din_data      (din_data),
    .din_ready     (din_ready),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: combinational read, clocked write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'(8'h10 + i);
    end else if (rf_write_en) begin
      rf[rf_write_addr] <= rf_write_data;
    end
  end
  assign rf_read_data = rf[rf_read_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Dump nbytes starting at st; rnd randomises dout_ready, poke offers a
  // stray command mid-dump that must be ignored.
  task automatic run_dump(input logic [2:0] st, input logic [3:0] cnt,
                          input int nbytes, input bit rnd, input bit poke);
    logic [2:0] a;
    logic [7:0] held;
    int         t_prev;
    int         w;
    int         k;
    dout_ready = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = 1'b0;
    cmd_start  = st;
    cmd_count  = cnt;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick;
    cmd_valid = 1'b0;
    chk("dump_busy", 32'(busy), 32'd1);
    chk("dump_cmd_ready_low", 32'(cmd_ready), 32'd0);
    chk("dump_lat_1", 32'(dout_valid), 32'd0);
    tick;
    chk("dump_lat_2", 32'(dout_valid), 32'd1);
    a      = st;
    t_prev = cyc;
    for (int i = 0; i < nbytes; i++) begin
      w = 0;
      while (!dout_valid && w < 20) begin
        tick;
        w++;
      end
      chk("dump_valid_timeout", 32'(dout_valid), 32'd1);
      chk("dump_data", 32'(dout_data), 32'(exp_rf[a]));
      if (!rnd && i > 0) chk("dump_gap", 32'(cyc - t_prev), 32'd2);
      t_prev = cyc;
      if (rnd) begin
        k = 0;
        while (k < 5 && $urandom_range(0, 1) == 0) begin
          dout_ready = 1'b0;
          held = dout_data;
          tick;
          chk("stall_valid", 32'(dout_valid), 32'd1);
          chk("stall_data", 32'(dout_data), 32'(held));
          k++;
        end
      end
      dout_ready = 1'b1;
      if (poke && i == 2) begin
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_start = 3'd5;
        cmd_count = 4'd1;
        chk("poke_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      tick;
      cmd_valid = 1'b0;
      if (i != nbytes - 1) begin
        chk("dump_no_early_done", 32'(done), 32'd0);
        chk("dump_busy_mid", 32'(busy), 32'd1);
      end
      a = a + 3'd1;
    end
    chk("dump_done", 32'(done), 32'd1);
    chk("dump_valid_clear", 32'(dout_valid), 32'd0);
    tick;
    chk("dump_done_pulse", 32'(done), 32'd0);
    chk("dump_idle", 32'(cmd_ready), 32'd1);
  endtask

  // Load nbytes from ld_bytes starting at st, one byte per cycle.
  task automatic run_load(input logic [2:0] st, input logic [3:0] cnt, input int nbytes);
    logic [2:0] a;
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    cmd_start = st;
    cmd_count = cnt;
    tick;
    cmd_valid = 1'b0;
    chk("load_din_ready", 32'(din_ready), 32'd1);
    chk("load_no_wr_yet", 32'(rf_write_en), 32'd0);
    a = st;
    for (int i = 0; i < nbytes; i++) begin
      din_valid = 1'b1;
      din_data  = ld_bytes[i];
      tick;
      chk("load_wr_en", 32'(rf_write_en), 32'd1);
      chk("load_wr_addr", 32'(rf_write_addr), 32'(a));
      chk("load_wr_data", 32'(rf_write_data), 32'(ld_bytes[i]));
      exp_rf[a] = ld_bytes[i];
      if (i != nbytes - 1) chk("load_no_early_done", 32'(done), 32'd0);
      a = a + 3'd1;
    end
    chk("load_done_with_last_wr", 32'(done), 32'd1);
    chk("load_din_ready_done", 32'(din_ready), 32'd0);
    din_valid = 1'b1;
    din_data  = 8'hEE;
    tick;
    din_valid = 1'b0;
    chk("load_done_byte_ignored", 32'(rf_write_en), 32'd0);
    chk("load_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    preload    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 1'b0;
    cmd_start  = 3'd0;
    cmd_count  = 4'd0;
    dout_ready = 1'b1;
    din_valid  = 1'b0;
    din_data   = 8'h00;
    for (int i = 0; i < 8; i++) exp_rf[i] = 8'(8'h10 + i);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_wr_en", 32'(rf_write_en), 32'd0);
    chk("rst_dout_data", 32'(dout_data), 32'd0);
    chk("rst_wr_addr", 32'(rf_write_addr), 32'd0);
    chk("rst_wr_data", 32'(rf_write_data), 32'd0);
    chk("rst_read_addr", 32'(rf_read_addr), 32'd0);
    rst     = 1'b0;
    preload = 1'b1;
    tick;
    preload = 1'b0;
    tick;

    // Full dump of the preloaded file.
    run_dump(3'd0, 4'd8, 8, 1'b0, 1'b0);

    // Wrapping load: R6, R7, R0.
    ld_bytes[0] = 8'hA1;
    ld_bytes[1] = 8'hA2;
    ld_bytes[2] = 8'hA3;
    run_load(3'd6, 4'd3, 3);

    // Count 0 and count 12 both sweep exactly eight registers.
    run_dump(3'd0, 4'd0, 8, 1'b0, 1'b0);
    run_dump(3'd5, 4'd12, 8, 1'b0, 1'b0);

    // Wrapping partial dump under random back-pressure with a stray command.
    run_dump(3'd6, 4'd4, 4, 1'b1, 1'b1);

    // Reset after two of five load bytes: second strobe is still pending.
    ld_bytes[0] = 8'hB1;
    ld_bytes[1] = 8'hB2;
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    cmd_start = 3'd2;
    cmd_count = 4'd5;
    tick;
    cmd_valid = 1'b0;
    din_valid = 1'b1;
    din_data  = 8'hB1;
    tick;
    chk("abort_wr1", 32'(rf_write_en), 32'd1);
    exp_rf[2] = 8'hB1;
    din_data  = 8'hB2;
    tick;
    chk("abort_wr2_pending", 32'(rf_write_en), 32'd1);
    din_data = 8'hB3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_din_ready", 32'(din_ready), 32'd0);
    chk("abort_wr_en", 32'(rf_write_en), 32'd0);
    repeat (3) tick;
    chk("abort_no_wr_in_rst", 32'(rf_write_en), 32'd0);
    din_valid = 1'b0;
    rst = 1'b0;
    tick;
    chk("abort_idle", 32'(cmd_ready), 32'd1);

    // New command after release; confirms only R2 changed.
    run_dump(3'd0, 4'd8, 8, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
